btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/debounce_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/btn_debounce.sv | 111 +++++++++++
 tb/tb_btn_debounce.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the button debouncer.
package debounce_pkg;

  // state      | meaning
  // LOW        | accepted level is 0, synchronized input agrees
  // CHK_HIGH   | accepted level is 0, counting consecutive high samples
  // HIGH       | accepted level is 1, synchronized input agrees
  // CHK_LOW    | accepted level is 1, counting consecutive low samples
  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } state_e;

  // Counter width able to hold STABLE_CYCLES-1 with one bit of headroom.
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the raw button level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  // Shift the asynchronous input through two stages; reset clears both.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/btn_debounce.sv
// Button debouncer: a new level is accepted only after STABLE_CYCLES
// consecutive equal synchronized samples; rise/fall pulse once per change.
//
// state      | meaning
// LOW        | level=0, waiting for a high sample
// CHK_HIGH   | level=0, cnt counts consecutive high samples seen so far
// HIGH       | level=1, waiting for a low sample
// CHK_LOW    | level=1, cnt counts consecutive low samples seen so far
module btn_debounce
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s2;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (s2)
  );

  // State, counter and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state logic; cnt holds the number of disagreeing samples already seen,
  // so it stops at STABLE_CYCLES-1 and clears on acceptance or abandon.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      LOW: begin
        if (s2) begin
          state_d = CHK_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_HIGH: begin
        if (!s2) begin
          state_d = LOW;
        end else if (cnt_q == CNT_TC) begin
          state_d = HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s2) begin
          state_d = CHK_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_LOW: begin
        if (s2) begin
          state_d = HIGH;
        end else if (cnt_q == CNT_TC) begin
          state_d = LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LOW;
        level_d = 1'b0;
      end
    endcase
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios at STABLE_CYCLES=4 and a long
// randomized run at STABLE_CYCLES=2, both against a run-length reference model.
module tb_btn_debounce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4 = 1'b1, btn4 = 1'b0, level4, rise4, fall4;
  logic rst2 = 1'b1, btn2 = 1'b0, level2, rise2, fall2;

  btn_debounce #(.STABLE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst4), .btn_in(btn4),
    .level(level4), .rise(rise4), .fall(fall4)
  );

  btn_debounce #(.STABLE_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst2), .btn_in(btn2),
    .level(level2), .rise(rise2), .fall(fall2)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int edge_n = 0;

  // Reference model state: two-sample input delay, accepted level, and the
  // length of the current run of samples that disagree with that level.
  logic m4_s1 = 0, m4_s2 = 0, m4_lvl = 0, m4_rise = 0, m4_fall = 0;
  int   m4_run = 0;
  logic m2_s1 = 0, m2_s2 = 0, m2_lvl = 0, m2_rise = 0, m2_fall = 0;
  int   m2_run = 0;

  task automatic model_step(input int sc, input logic b, input logic r,
                            inout logic s1, inout logic s2, inout logic lvl,
                            inout int run, output logic rs, output logic fl);
    rs = 1'b0;
    fl = 1'b0;
    if (r) begin
      s1 = 1'b0; s2 = 1'b0; lvl = 1'b0; run = 0;
    end else begin
      if (s2 != lvl) begin
        run = run + 1;
        if (run == sc) begin
          lvl = ~lvl;
          rs  = lvl;
          fl  = ~lvl;
          run = 0;
        end
      end else begin
        run = 0;
      end
      s2 = s1;
      s1 = b;
    end
  endtask

  // One clock edge: advance both models with the inputs the DUTs sampled,
  // then settle 1 time unit past the edge before anyone looks at outputs.
  task automatic tick();
    @(posedge clk);
    model_step(4, btn4, rst4, m4_s1, m4_s2, m4_lvl, m4_run, m4_rise, m4_fall);
    model_step(2, btn2, rst2, m2_s1, m2_s2, m2_lvl, m2_run, m2_rise, m2_fall);
    edge_n++;
    #1;
  endtask

  task automatic test_reset();
    logic exp_lvl, exp_rise;
    rst4 = 1'b1; btn4 = 1'b0;
    repeat (3) begin
      tick();
      tests_run++;
      if ({level4, rise4, fall4} !== 3'b000) begin
        tests_failed++;
        $display("FAIL reset_outputs edge %0d: got l/r/f=%b%b%b expected 000", edge_n, level4, rise4, fall4);
      end
    end
    rst4 = 1'b0;
    while (edge_n < 17) begin
      btn4 = (edge_n + 1 >= 10);
      tick();
      exp_lvl  = (edge_n >= 15);
      exp_rise = (edge_n == 15);
      tests_run++;
      if ({level4, rise4, fall4} !== {exp_lvl, exp_rise, 1'b0}) begin
        tests_failed++;
        $display("FAIL rise_latency edge %0d: got l/r/f=%b%b%b expected %b%b0", edge_n, level4, rise4, fall4, exp_lvl, exp_rise);
      end
    end
  endtask

  task automatic test_glitch();
    rst4 = 1'b1; btn4 = 1'b0;
    tick();
    rst4 = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 15; i++) begin
      btn4 = (i < 3);
      tick();
      tests_run++;
      if ({level4, rise4, fall4} !== 3'b000 || level4 !== m4_lvl) begin
        tests_failed++;
        $display("FAIL short_high_run step %0d: got l/r/f=%b%b%b expected 000", i, level4, rise4, fall4);
      end
    end
  endtask

  task automatic test_bounce();
    logic pat [7];
    int   falls;
    logic exp_lvl, exp_fall;
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    falls = 0;
    btn4 = 1'b1;
    repeat (10) tick();
    tests_run++;
    if (level4 !== 1'b1) begin
      tests_failed++;
      $display("FAIL reach_high: got level=%b expected 1", level4);
    end
    for (int i = 0; i < 17; i++) begin
      btn4 = (i < 7) ? pat[i] : 1'b0;
      tick();
      if (fall4 === 1'b1) falls++;
      exp_lvl  = (i < 8);
      exp_fall = (i == 8);
      tests_run++;
      if ({level4, rise4, fall4} !== {exp_lvl, 1'b0, exp_fall} ||
          {level4, rise4, fall4} !== {m4_lvl, m4_rise, m4_fall}) begin
        tests_failed++;
        $display("FAIL bounce_fall step %0d: got l/r/f=%b%b%b expected %b0%b", i, level4, rise4, fall4, exp_lvl, exp_fall);
      end
    end
    tests_run++;
    if (falls != 1) begin
      tests_failed++;
      $display("FAIL bounce_fall_count: got %0d expected 1", falls);
    end
  endtask

  task automatic test_reset_mid();
    logic exp_lvl, exp_rise;
    rst4 = 1'b1; btn4 = 1'b0;
    tick();
    rst4 = 1'b0;
    repeat (3) tick();
    btn4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (rise4 !== 1'b0 || level4 !== 1'b0) begin
        tests_failed++;
        $display("FAIL pre_reset_check step %0d: got l/r=%b%b expected 00", i, level4, rise4);
      end
    end
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    tests_run++;
    if ({level4, rise4, fall4} !== 3'b000) begin
      tests_failed++;
      $display("FAIL mid_check_reset: got l/r/f=%b%b%b expected 000", level4, rise4, fall4);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_lvl  = (i >= 6);
      exp_rise = (i == 6);
      tests_run++;
      if ({level4, rise4, fall4} !== {exp_lvl, exp_rise, 1'b0} ||
          {level4, rise4, fall4} !== {m4_lvl, m4_rise, m4_fall}) begin
        tests_failed++;
        $display("FAIL post_reset_latency sample %0d: got l/r/f=%b%b%b expected %b%b0", i, level4, rise4, fall4, exp_lvl, exp_rise);
      end
    end
  endtask

  task automatic test_random();
    int   hold, rises, falls, diff;
    logic last_rise;
    hold = 0; rises = 0; falls = 0; last_rise = 1'b0;
    rst2 = 1'b1; btn2 = 1'b0;
    tick();
    rst2 = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (hold == 0) begin
        btn2 = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 4);
      end
      hold--;
      tick();
      tests_run++;
      if ({level2, rise2, fall2} !== {m2_lvl, m2_rise, m2_fall}) begin
        tests_failed++;
        $display("FAIL random_model cycle %0d: got l/r/f=%b%b%b expected %b%b%b", i, level2, rise2, fall2, m2_lvl, m2_rise, m2_fall);
      end
      if (rise2 === 1'b1 || fall2 === 1'b1) begin
        tests_run++;
        if ((rise2 === 1'b1 && fall2 === 1'b1) || (rise2 === 1'b1 && last_rise) ||
            (fall2 === 1'b1 && !last_rise)) begin
          tests_failed++;
          $display("FAIL pulse_alternation cycle %0d: got r/f=%b%b after last_rise=%b", i, rise2, fall2, last_rise);
        end
        if (rise2 === 1'b1) begin rises++; last_rise = 1'b1; end
        if (fall2 === 1'b1) begin falls++; last_rise = 1'b0; end
      end
    end
    diff = rises - falls;
    tests_run++;
    if (rises == 0 || diff < 0 || diff > 1) begin
      tests_failed++;
      $display("FAIL pulse_counts: got rises=%0d falls=%0d expected nonzero, differing by 0..1", rises, falls);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_bounce();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
